gan_serial_engine: RTL and testbench
====================================

// Module: gan_serial_engine
// PURPOSE
//  Serial-input GAN core: collects a PIXEL_COUNT-bit binary frame one bit per handshake, then on
//  start runs a generator (LFSR-driven Q8.8 fake frame) and a discriminator that scores the real and
//  fake frames. Sits under the frame-level controller, which serializes a sample frame and pulses start.
// PARAMETERS
//  PIXEL_COUNT     784          pixels per frame (28x28)
//  LFSR_SEED       16'hACE1     generator LFSR seed, reloaded at every accepted start (nonzero)
//  ON_LEVEL        16'h0080     fake pixel counts as "on" when unsigned value >= ON_LEVEL (0.5 Q8.8)
//  REAL_THRESHOLD  16'sd0       is_real when signed score > REAL_THRESHOLD
// PORTS
//  clk                    in   1         single clock, rising edge
//  rst                    in   1         synchronous, active-high reset
//  pixel_bit              in   1         serial pixel value (1 = on)
//  pixel_bit_valid        in   1         pixel_bit valid
//  pixel_bit_ready        out  1         loader can accept a bit
//  start                  in   1         run request
//  busy                   out  1         run in progress
//  done                   out  1         one-cycle pulse, results valid
//  disc_fake_is_real      out  1         fake score > REAL_THRESHOLD
//  disc_real_is_real      out  1         real score > REAL_THRESHOLD
//  disc_fake_score        out  16 s      fake frame score
//  disc_real_score        out  16 s      real frame score
//  generated_frame_flat   out  16*PC     fake frame, pixel i at [16i+15:16i], Q8.8
//  generated_frame_valid  out  1         generated_frame_flat holds a completed frame
//  frame_ready            out  1         full frame loaded, start will be accepted
// BEHAVIOUR
//  Reset: all outputs 0 except pixel_bit_ready=1; bit count 0, state LOAD. Reset mid-run aborts fully.
//  States: LOAD -> FULL -> RUN -> FIN -> LOAD.
//  LOAD: pixel_bit_ready=1; bit stored at index=count on valid&ready, count++; after bit PIXEL_COUNT-1
//   -> FULL next cycle (pixel_bit_ready=0, frame_ready=1). Valid while not ready is ignored.
//  start ignored unless state==FULL. FULL&start: LFSR<=LFSR_SEED, scores<=0, idx<=0,
//   generated_frame_valid<=0, busy<=1 -> RUN.
//  RUN: one pixel per cycle, idx 0..PIXEL_COUNT-1: fake_i = {8'h00, lfsr[7:0]} written to slot i;
//   then LFSR steps Galois right-shift, taps mask 16'hB400. Pixel 0 uses the seed (0x00E1).
//   real_acc += bit_i ? +1 : -1; fake_acc += (fake_i >= ON_LEVEL) ? +1 : -1 (range +-784, no overflow).
//   After idx PIXEL_COUNT-1 -> FIN.
//  FIN (1 cycle): scores and is_real flags registered, done=1, busy=0, generated_frame_valid=1,
//   frame_ready=0, count=0 -> LOAD. done = PIXEL_COUNT+1 cycles after the start cycle.
//  Scores/flags/generated frame hold until next accepted start (frame) or reset.
//  start during RUN/FIN/LOAD has no effect; pixel bits during RUN are not accepted.
// CONFIGURATION
//  GAN_SERIAL_TRACE_EN defined: $display on frame-full, start accept and done (with both scores).
//  Undefined: no simulation output; RTL behaviour identical either way.
// STRUCTURE
//  gan_serial_pkg: PIXEL_COUNT default, state enum, q8_8_t typedef, LFSR taps constant.
//  Sub-module gan_frame_loader: bit handshake, frame register, count, frame_ready; core holds FSM,
//  LFSR and score accumulators.
// TESTING
//  Load 784 ones, start -> done after 785 cycles, real score +784, disc_real_is_real=1.
//  Load 784 zeros -> real score -784, disc_real_is_real=0; fake score equals software LFSR model.
//  generated_frame_flat[15:0]==16'h00E1 and word1 == one LFSR step of 0xACE1 (low byte); identical
//   results on a second run with same frame (seed reload).
//  Pulse start before frame full -> no busy, no done; pixel_bit_ready=0 after 784th bit.
//  Assert rst mid-RUN -> busy/done/frame_ready 0, pixel_bit_ready 1, count restarts at 0.
//  Back-to-back: reload frame with valid gaps -> frame_ready only after all 784 bits, second run OK.

Source files
------------

// File: rtl/gan_serial_pkg.sv
// Shared types and constants for the serial GAN engine.
// Build option: GAN_SERIAL_TRACE_EN enables simulation trace output in the core.
package gan_serial_pkg;

    localparam int          PIXEL_COUNT_DEF = 784;
    localparam logic [15:0] LFSR_TAPS       = 16'hB400;

    typedef logic [15:0] q8_8_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FULL,
        ST_RUN,
        ST_FIN
    } state_t;

    // Galois right-shift step of the generator LFSR
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/gan_serial_engine_loader.sv
// Serial frame loader: bit handshake, frame register and fill counter.
// Build option: none (GAN_SERIAL_TRACE_EN only affects the core).
module gan_frame_loader
    import gan_serial_pkg::*;
#(
    parameter int PIXEL_COUNT = PIXEL_COUNT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pixel_bit,
    input  logic                   pixel_bit_valid,
    input  logic                   load_en,
    input  logic                   consume,
    output logic                   pixel_bit_ready,
    output logic                   frame_ready,
    output logic                   last_bit,
    output logic [PIXEL_COUNT-1:0] frame_bits
);

    localparam int CW = $clog2(PIXEL_COUNT);

    logic [CW-1:0] count;
    logic          full;
    logic          accept;

    assign pixel_bit_ready = load_en & ~full;
    assign accept          = pixel_bit_valid & pixel_bit_ready;
    assign last_bit        = accept && (count == CW'(PIXEL_COUNT - 1));
    assign frame_ready     = full;

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            full       <= 1'b0;
            frame_bits <= '0;
        end else begin
            if (accept) begin
                frame_bits[count] <= pixel_bit;
                count             <= last_bit ? '0 : count + 1'b1;
            end
            if (last_bit) begin
                full <= 1'b1;
            end else if (consume) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gan_serial_engine.sv
// Serial-input GAN core: LFSR generator plus +-1 accumulating discriminator.
// Build option: define GAN_SERIAL_TRACE_EN for $display trace of full/start/done.
module gan_serial_engine
    import gan_serial_pkg::*;
#(
    parameter int                 PIXEL_COUNT    = PIXEL_COUNT_DEF,
    parameter logic [15:0]        LFSR_SEED      = 16'hACE1,
    parameter logic [15:0]        ON_LEVEL       = 16'h0080,
    parameter logic signed [15:0] REAL_THRESHOLD = 16'sd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pixel_bit,
    input  logic                      pixel_bit_valid,
    output logic                      pixel_bit_ready,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      disc_fake_is_real,
    output logic                      disc_real_is_real,
    output logic signed [15:0]        disc_fake_score,
    output logic signed [15:0]        disc_real_score,
    output logic [16*PIXEL_COUNT-1:0] generated_frame_flat,
    output logic                      generated_frame_valid,
    output logic                      frame_ready
);

    localparam int CW = $clog2(PIXEL_COUNT);

    state_t                   state;
    state_t                   state_nxt;
    logic                     start_acc;
    logic                     last_bit;
    logic                     last_pix;
    logic [PIXEL_COUNT-1:0]   frame_bits;
    logic [15:0]              lfsr;
    logic [CW-1:0]            idx;
    q8_8_t                    fake_pix;
    logic signed [15:0]       real_acc;
    logic signed [15:0]       fake_acc;
    logic signed [15:0]       real_nxt;
    logic signed [15:0]       fake_nxt;

    gan_frame_loader #(
        .PIXEL_COUNT(PIXEL_COUNT)
    ) u_loader (
        .clk            (clk),
        .rst            (rst),
        .pixel_bit      (pixel_bit),
        .pixel_bit_valid(pixel_bit_valid),
        .load_en        (state == ST_LOAD),
        .consume        (start_acc),
        .pixel_bit_ready(pixel_bit_ready),
        .frame_ready    (frame_ready),
        .last_bit       (last_bit),
        .frame_bits     (frame_bits)
    );

    assign start_acc = (state == ST_FULL) && start;
    assign last_pix  = (idx == CW'(PIXEL_COUNT - 1));
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_LOAD: if (last_bit)  state_nxt = ST_FULL;
            ST_FULL: if (start)     state_nxt = ST_RUN;
            ST_RUN:  if (last_pix)  state_nxt = ST_FIN;
            ST_FIN:                 state_nxt = ST_LOAD;
            default:                state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        fake_pix = {8'h00, lfsr[7:0]};
        real_nxt = frame_bits[idx] ? real_acc + 16'sd1 : real_acc - 16'sd1;
        fake_nxt = (fake_pix >= ON_LEVEL) ? fake_acc + 16'sd1
                                          : fake_acc - 16'sd1;
    end

    // Outputs are only published on the last pixel so they hold between runs
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr                  <= LFSR_SEED;
            idx                   <= '0;
            real_acc              <= '0;
            fake_acc              <= '0;
            disc_real_score       <= '0;
            disc_fake_score       <= '0;
            disc_real_is_real     <= 1'b0;
            disc_fake_is_real     <= 1'b0;
            generated_frame_flat  <= '0;
            generated_frame_valid <= 1'b0;
        end else if (start_acc) begin
            lfsr                  <= LFSR_SEED;
            idx                   <= '0;
            real_acc              <= '0;
            fake_acc              <= '0;
            disc_real_score       <= '0;
            disc_fake_score       <= '0;
            disc_real_is_real     <= 1'b0;
            disc_fake_is_real     <= 1'b0;
            generated_frame_valid <= 1'b0;
        end else if (state == ST_RUN) begin
            generated_frame_flat[32'(idx)*16 +: 16] <= fake_pix;
            lfsr     <= lfsr_step(lfsr);
            idx      <= idx + 1'b1;
            real_acc <= real_nxt;
            fake_acc <= fake_nxt;
            if (last_pix) begin
                disc_real_score       <= real_nxt;
                disc_fake_score       <= fake_nxt;
                disc_real_is_real     <= real_nxt > REAL_THRESHOLD;
                disc_fake_is_real     <= fake_nxt > REAL_THRESHOLD;
                generated_frame_valid <= 1'b1;
            end
        end
    end

`ifdef GAN_SERIAL_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (last_bit)
                $display("gan: frame full");
            if (start_acc)
                $display("gan: start accepted");
            if (state == ST_FIN)
                $display("gan: done real=%0d fake=%0d",
                         disc_real_score, disc_fake_score);
        end
    end
`else
    // silent build
`endif

endmodule

// File: tb/tb_gan_serial_engine.sv
// Self-checking bench for gan_serial_engine.
// Vector table of frames plus a scoreboard queue of expected results.
module tb_gan_serial_engine;

    localparam int PC = 784;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               pixel_bit = 1'b0;
    logic               pixel_bit_valid = 1'b0;
    logic               pixel_bit_ready;
    logic               start = 1'b0;
    logic               busy;
    logic               done;
    logic               disc_fake_is_real;
    logic               disc_real_is_real;
    logic signed [15:0] disc_fake_score;
    logic signed [15:0] disc_real_score;
    logic [16*PC-1:0]   generated_frame_flat;
    logic               generated_frame_valid;
    logic               frame_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic signed [15:0] real_s;
        logic               real_r;
        logic signed [15:0] fake_s;
        logic               fake_r;
    } exp_t;

    typedef struct {
        int                 mode;
        bit                 gaps;
        logic signed [15:0] exp_real;
        logic               exp_real_r;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];

    gan_serial_engine dut (
        .clk                  (clk),
        .rst                  (rst),
        .pixel_bit            (pixel_bit),
        .pixel_bit_valid      (pixel_bit_valid),
        .pixel_bit_ready      (pixel_bit_ready),
        .start                (start),
        .busy                 (busy),
        .done                 (done),
        .disc_fake_is_real    (disc_fake_is_real),
        .disc_real_is_real    (disc_real_is_real),
        .disc_fake_score      (disc_fake_score),
        .disc_real_score      (disc_real_score),
        .generated_frame_flat (generated_frame_flat),
        .generated_frame_valid(generated_frame_valid),
        .frame_ready          (frame_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic signed [15:0] fake_model();
        logic [15:0] l;
        int acc;
        l = 16'hACE1;
        acc = 0;
        for (int i = 0; i < PC; i++) begin
            acc = ({8'h00, l[7:0]} >= 16'h0080) ? acc + 1 : acc - 1;
            l = step(l);
        end
        return 16'(acc);
    endfunction

    function automatic logic bit_of(input int mode, input int i);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (i % 2) == 1;
            default: return i < 400;
        endcase
    endfunction

    task automatic load_frame(input int mode, input bit gaps,
                              input int first, input int last);
        int  i;
        int  guard;
        bit  seen;
        i = first;
        guard = 0;
        seen = 0;
        while (i < last && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 3) == 0) begin
                pixel_bit_valid = 1'b0;
            end else begin
                if (i == PC - 1 && !seen) begin
                    seen = 1;
                    chk("frame_ready_early", frame_ready, 0);
                end
                pixel_bit       = bit_of(mode, i);
                pixel_bit_valid = 1'b1;
                if (pixel_bit_ready) i++;
            end
        end
        @(negedge clk);
        pixel_bit_valid = 1'b0;
        if (guard >= 5000) chk("load_timeout", i, last);
        if (last == PC) begin
            chk("frame_ready_full", frame_ready, 1);
            chk("ready_low_full", pixel_bit_ready, 0);
        end
    endtask

    task automatic do_run(input string tag, input exp_t e_in);
        int          n;
        int          mism;
        exp_t        e;
        logic [15:0] l;
        sb.push_back(e_in);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk({tag, "_busy"}, busy, 1);
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 785);
        e = sb.pop_front();
        chk({tag, "_real_score"}, disc_real_score, e.real_s);
        chk({tag, "_real_is_real"}, disc_real_is_real, e.real_r);
        chk({tag, "_fake_score"}, disc_fake_score, e.fake_s);
        chk({tag, "_fake_is_real"}, disc_fake_is_real, e.fake_r);
        chk({tag, "_busy_fin"}, busy, 0);
        chk({tag, "_gen_valid"}, generated_frame_valid, 1);
        chk({tag, "_word0"}, generated_frame_flat[15:0], 16'h00E1);
        l = step(16'hACE1);
        chk({tag, "_word1"}, generated_frame_flat[31:16], {8'h00, l[7:0]});
        mism = 0;
        l = 16'hACE1;
        for (int i = 0; i < PC; i++) begin
            if (generated_frame_flat[16*i +: 16] !== {8'h00, l[7:0]}) mism++;
            l = step(l);
        end
        chk({tag, "_gen_frame"}, mism, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_ready_after"}, pixel_bit_ready, 1);
        chk({tag, "_frame_ready_after"}, frame_ready, 0);
        chk({tag, "_hold_score"}, disc_real_score, e.real_s);
    endtask

    initial begin
        logic signed [15:0] fm;
        exp_t e;
        int   hits;

        fm = fake_model();
        vecs[0] = '{mode: 1, gaps: 0, exp_real: 16'sd784,  exp_real_r: 1'b1};
        vecs[1] = '{mode: 0, gaps: 0, exp_real: -16'sd784, exp_real_r: 1'b0};
        vecs[2] = '{mode: 0, gaps: 1, exp_real: -16'sd784, exp_real_r: 1'b0};
        vecs[3] = '{mode: 2, gaps: 1, exp_real: 16'sd0,    exp_real_r: 1'b0};
        vecs[4] = '{mode: 3, gaps: 0, exp_real: 16'sd16,   exp_real_r: 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", pixel_bit_ready, 1);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_real_score", disc_real_score, 0);
        chk("rst_fake_score", disc_fake_score, 0);
        chk("rst_gen_valid", generated_frame_valid, 0);
        chk("rst_gen_zero", |generated_frame_flat, 0);

        // start before the frame is full must do nothing
        load_frame(1, 0, 0, 100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || done) hits++;
        end
        chk("early_start_ignored", hits, 0);
        chk("early_ready", pixel_bit_ready, 1);
        load_frame(1, 0, 100, PC);
        e = '{real_s: 16'sd784, real_r: 1'b1,
              fake_s: fm, fake_r: fm > 0};
        do_run("early", e);

        foreach (vecs[k]) begin
            load_frame(vecs[k].mode, vecs[k].gaps, 0, PC);
            if (vecs[k].gaps) begin
                pixel_bit_valid = 1'b1;
                repeat (3) @(negedge clk);
                pixel_bit_valid = 1'b0;
                chk($sformatf("v%0d_still_full", k), frame_ready, 1);
            end
            e = '{real_s: vecs[k].exp_real, real_r: vecs[k].exp_real_r,
                  fake_s: fm, fake_r: fm > 0};
            do_run($sformatf("v%0d", k), e);
        end

        // reset in the middle of a run aborts everything
        load_frame(1, 0, 0, PC);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_frame_ready", frame_ready, 0);
        chk("mid_rst_ready", pixel_bit_ready, 1);
        chk("mid_rst_gen_valid", generated_frame_valid, 0);
        load_frame(0, 1, 0, PC);
        e = '{real_s: -16'sd784, real_r: 1'b0,
              fake_s: fm, fake_r: fm > 0};
        do_run("after_rst", e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
